free_list: RTL

- Circular FIFO of free physical register tags for the 2-wide R10K-style rename stage.
- Feeds the ROB and Map Table with new tags T_idx at dispatch.
- Reclaims retired Told_idx tags from the ROB at retire.
- Restores its allocation pointer on branch rollback from a pointer checkpoint captured at dispatch.

---
 rtl/free_list.sv | 108 ++++++++++
 1 files changed

// File: rtl/free_list.sv
// Free list of physical register tags for the 2-wide rename stage.
// Tags are allocated at dispatch, reclaimed at retire, and the head is restored on rollback.
module free_list #(
  parameter int NUM_SUPER = 2,
  parameter int NUM_PR    = 64,
  parameter int NUM_ARCH  = 32,
  parameter int ZERO_REG  = 31,
  parameter int ZERO_PR   = 31
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   dispatch_en,
  input  logic [NUM_SUPER*5-1:0] dest_idx,
  input  logic [NUM_SUPER-1:0]   retire_en,
  input  logic [NUM_SUPER*5-1:0] retire_dest_idx,
  input  logic [NUM_SUPER*6-1:0] Told_idx,
  input  logic                   rollback_en,
  input  logic [5:0]             FL_rollback_idx,
  output logic                   FL_valid,
  output logic [NUM_SUPER*6-1:0] T_idx,
  output logic [NUM_SUPER*6-1:0] FL_idx,
  output logic [5:0]             free_count
);

  localparam int FL_SIZE = NUM_PR - NUM_ARCH;
  localparam int AREG_W  = 5;
  localparam int TAG_W   = 6;
  localparam int IDX_W   = 5;
  localparam int PTR_W   = IDX_W + 1;

  localparam logic [AREG_W-1:0] ZERO_AREG = AREG_W'(ZERO_REG);
  localparam logic [TAG_W-1:0]  ZERO_TAG  = TAG_W'(ZERO_PR);

  logic [TAG_W-1:0] entry_reg [FL_SIZE];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;

  logic [NUM_SUPER-1:0] need;
  logic [NUM_SUPER-1:0] free;
  logic [PTR_W-1:0]     need_pre [NUM_SUPER+1];
  logic [PTR_W-1:0]     free_pre [NUM_SUPER+1];
  logic [PTR_W-1:0]     wr_ptr   [NUM_SUPER];
  logic [PTR_W-1:0]     need_cnt;
  logic [PTR_W-1:0]     free_cnt;

  // Prefix counts compact the active slots: each slot's offset is the number of active slots before it.
  always_comb begin
    need_pre[0] = '0;
    free_pre[0] = '0;
    for (int i = 0; i < NUM_SUPER; i++) begin
      need_pre[i+1] = need_pre[i] + {{(PTR_W-1){1'b0}}, need[i]};
      free_pre[i+1] = free_pre[i] + {{(PTR_W-1){1'b0}}, free[i]};
      wr_ptr[i]     = tail_reg + free_pre[i];
    end
  end

  assign need_cnt   = need_pre[NUM_SUPER];
  assign free_cnt   = free_pre[NUM_SUPER];
  assign free_count = tail_reg - head_reg;
  assign FL_valid   = (free_count >= need_cnt) && !rollback_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SUPER; gi++) begin : g_slot
      logic [PTR_W-1:0] rd_ptr;

      assign need[gi] = dest_idx[gi*AREG_W +: AREG_W] != ZERO_AREG;
      assign free[gi] = retire_en[gi] && (retire_dest_idx[gi*AREG_W +: AREG_W] != ZERO_AREG);
      assign rd_ptr   = head_reg + need_pre[gi];

      assign T_idx[gi*TAG_W +: TAG_W]  = need[gi] ? entry_reg[rd_ptr[IDX_W-1:0]] : ZERO_TAG;
      assign FL_idx[gi*PTR_W +: PTR_W] = head_reg + need_pre[gi+1];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        entry_reg[i] <= TAG_W'(NUM_ARCH + i);
      end
      head_reg <= '0;
      tail_reg <= PTR_W'(FL_SIZE);
    end else if (en) begin
      if (rollback_en) begin
        head_reg <= FL_rollback_idx;
      end else if (dispatch_en && FL_valid) begin
        head_reg <= head_reg + need_cnt;
      end
      // Retire is independent of rollback; the tail always advances by the freed count.
      for (int i = 0; i < NUM_SUPER; i++) begin
        if (free[i]) begin
          entry_reg[wr_ptr[i][IDX_W-1:0]] <= Told_idx[i*TAG_W +: TAG_W];
        end
      end
      tail_reg <= tail_reg + free_cnt;
    end
  end

`ifndef SYNTHESIS
  a_dispatch_needs_valid: assert property (@(posedge clock) disable iff (reset)
    (en && dispatch_en && !rollback_en) |-> FL_valid);

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    en |-> ({1'b0, free_count} + {1'b0, free_cnt} <= 7'(FL_SIZE)));
`endif

endmodule
